color_decl_sequencer: RTL

COLOR_DECL_SEQUENCER -- requirements
Module: color_decl_sequencer

---
 rtl/css_seq_pkg.sv | 30 +++
 rtl/decl_buffer.sv | 20 ++
 rtl/color_decl_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/css_seq_pkg.sv
// Shared types and sizing for the color declaration sequencer.
// Each buffered entry is one packed decl_t.
package css_seq_pkg;
  localparam int DEPTH      = 8;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 4;
  localparam int CLASS_W    = 6;
  localparam int UNIT_W     = 7;
  localparam int DATA_W     = 32;
  localparam int LM_W       = 2;
  localparam int ENTRY_W    = CLASS_W + UNIT_W + 2 * DATA_W + LM_W + 1;
  localparam int LM_REGULAR = 0;
  localparam int LM_VISITED = 1;

  typedef enum logic [1:0] {
    COLLECT,
    PASS_NORMAL,
    PASS_IMPORTANT,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [CLASS_W-1:0] class_type;
    logic [UNIT_W-1:0]  unit_type;
    logic [DATA_W-1:0]  ident;
    logic [DATA_W-1:0]  rgbcolor;
    logic [LM_W-1:0]    link_match;
    logic               important;
  } decl_t;
endpackage

// File: rtl/decl_buffer.sv
// Declaration register file: one synchronous write port, one async read port.
// Contents are not reset; the sequencer never reads an unwritten slot.
module decl_buffer
  import css_seq_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);
  logic [DEPTH-1:0][ENTRY_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/color_decl_sequencer.sv
// Collects an element's color declarations, then replays them in a normal pass
// followed by an !important pass, flagging which style(s) each entry applies to.
module color_decl_sequencer
  import css_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class_type,
  input  logic [UNIT_W-1:0]  in_unit_type,
  input  logic [DATA_W-1:0]  in_ident,
  input  logic [DATA_W-1:0]  in_rgbcolor,
  input  logic [LM_W-1:0]    in_link_match,
  input  logic               in_important,
  input  logic               in_last,
  input  logic               in_inside_visited,
  output logic [CLASS_W-1:0] out_class_type,
  output logic [UNIT_W-1:0]  out_unit_type,
  output logic [DATA_W-1:0]  out_ident,
  output logic [DATA_W-1:0]  out_rgbcolor,
  output logic               out_apply_regular,
  output logic               out_apply_visited,
  output logic               busy,
  output logic               done,
  output logic               overflow
);
  seq_state_t       state;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx;
  logic             inside_visited_q;
  logic             overflow_q;

  logic  accept;
  logic  at_last_idx;
  logic  full_next;
  decl_t wr_entry;
  decl_t rd_entry;

  assign in_ready    = (state == COLLECT) && (count < CNT_W'(DEPTH));
  assign accept      = in_valid && in_ready;
  assign full_next   = (count == CNT_W'(DEPTH - 1));
  assign at_last_idx = (CNT_W'(idx) == count - CNT_W'(1));

  assign wr_entry = '{class_type: in_class_type, unit_type: in_unit_type,
                      ident: in_ident, rgbcolor: in_rgbcolor,
                      link_match: in_link_match, important: in_important};

  decl_buffer u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (count[IDX_W-1:0]),
    .wdata (wr_entry),
    .raddr (idx),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= COLLECT;
      count            <= '0;
      idx              <= '0;
      inside_visited_q <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (in_last) inside_visited_q <= in_inside_visited;
            // A full buffer forces the passes even without a terminating beat.
            if (in_last || full_next) begin
              state <= PASS_NORMAL;
              idx   <= '0;
            end
            if (!in_last && full_next) overflow_q <= 1'b1;
          end
        end
        PASS_NORMAL: begin
          if (at_last_idx) begin
            state <= PASS_IMPORTANT;
            idx   <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        PASS_IMPORTANT: begin
          if (at_last_idx) begin
            state <= DONE;
            idx   <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          state <= COLLECT;
          count <= '0;
          idx   <= '0;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  logic in_pass;
  logic match;

  assign in_pass = (state == PASS_NORMAL) || (state == PASS_IMPORTANT);
  assign match   = ((state == PASS_NORMAL) && !rd_entry.important) ||
                   ((state == PASS_IMPORTANT) && rd_entry.important);

  assign out_class_type    = in_pass ? rd_entry.class_type : '0;
  assign out_unit_type     = in_pass ? rd_entry.unit_type  : '0;
  assign out_ident         = in_pass ? rd_entry.ident      : '0;
  assign out_rgbcolor      = in_pass ? rd_entry.rgbcolor   : '0;
  assign out_apply_regular = match && rd_entry.link_match[LM_REGULAR];
  assign out_apply_visited = match && rd_entry.link_match[LM_VISITED] && inside_visited_q;

  assign busy     = (state != COLLECT);
  assign done     = (state == DONE);
  assign overflow = overflow_q;
endmodule
